// File: rtl/id_ex_reg.sv
// ---------------------------------------------------------------------------
// id_ex_reg
// Pipeline register between the decode (ID) and execute (EX) stages.
// Captures decoded operands, register numbers, immediate, PC+2 and control
// bits once per clock, with stall/flush handling. A writeback bypass makes
// sure operands read this cycle see a register-file write landing in the
// same cycle. A sticky halted flag stops any instruction from following HLT
// into EX.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   stall, flush          hold ID/EX contents / load a bubble (flush wins)
//   id_valid              decode stage presents a real instruction
//   id_rd1, id_rd2        register-file read data
//   id_src1, id_src2      source register numbers
//   id_dst                destination register number
//   id_imm, id_pc2        sign-extended immediate, PC+2
//   id_ctrl               {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, ALUOp[3:0]}
//   id_halt               decoded HLT
//   wb_we, wb_dst, wb_data  writeback port writing the register file this cycle
//   ex_*                  registered EX-stage copies of the id_* fields
//   halted                sticky: a valid HLT has entered EX
// ---------------------------------------------------------------------------
module id_ex_reg #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [3:0]        id_src1,
  input  logic [3:0]        id_src2,
  input  logic [3:0]        id_dst,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc2,
  input  logic [8:0]        id_ctrl,
  input  logic              id_halt,
  input  logic              wb_we,
  input  logic [3:0]        wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [3:0]        ex_src1,
  output logic [3:0]        ex_src2,
  output logic [3:0]        ex_dst,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc2,
  output logic [8:0]        ex_ctrl,
  output logic              ex_halt,
  output logic              halted
);

  // Writeback match terms. Register 0 is hard-wired, so a write to it is
  // never forwarded. The id_* matches feed a normal capture; the ex_*
  // matches refresh operands that are being held by a stall.
  logic wb_live;
  logic byp_id1, byp_id2;
  logic byp_ex1, byp_ex2;

  always_comb begin
    wb_live = wb_we && (wb_dst != 4'd0);
    byp_id1 = wb_live && (wb_dst == id_src1);
    byp_id2 = wb_live && (wb_dst == id_src2);
    byp_ex1 = wb_live && ex_valid && (wb_dst == ex_src1);
    byp_ex2 = wb_live && ex_valid && (wb_dst == ex_src2);
  end

  // Main ID/EX register. Ordering of the branches encodes the priority:
  // reset, then flush (or a capture after halt, which also becomes a
  // bubble), then stall, then normal capture. A stall after halt still
  // holds, so the HLT itself stays visible in EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_rd1   <= '0;
      ex_rd2   <= '0;
      ex_src1  <= '0;
      ex_src2  <= '0;
      ex_dst   <= '0;
      ex_imm   <= '0;
      ex_pc2   <= '0;
      ex_ctrl  <= '0;
      ex_halt  <= 1'b0;
      halted   <= 1'b0;
    end else if (flush || (halted && !stall)) begin
      ex_valid <= 1'b0;
      ex_rd1   <= '0;
      ex_rd2   <= '0;
      ex_src1  <= '0;
      ex_src2  <= '0;
      ex_dst   <= '0;
      ex_imm   <= '0;
      ex_pc2   <= '0;
      ex_ctrl  <= '0;
      ex_halt  <= 1'b0;
    end else if (stall) begin
      // Held instruction still has to observe a register write that lands
      // while it waits; nothing else moves.
      if (byp_ex1) ex_rd1 <= wb_data;
      if (byp_ex2) ex_rd2 <= wb_data;
    end else begin
      ex_valid <= id_valid;
      ex_rd1   <= byp_id1 ? wb_data : id_rd1;
      ex_rd2   <= byp_id2 ? wb_data : id_rd2;
      ex_src1  <= id_src1;
      ex_src2  <= id_src2;
      ex_dst   <= id_dst;
      ex_imm   <= id_imm;
      ex_pc2   <= id_pc2;
      // An invalid slot must not carry side-effecting control into EX.
      ex_ctrl  <= id_valid ? id_ctrl : 9'd0;
      ex_halt  <= id_valid && id_halt;
      if (id_valid && id_halt) halted <= 1'b1;
    end
  end

endmodule
